// File: rtl/sm_nrdiv_iter.sv
// Iterative sign-magnitude non-restoring divider: WIDTH+2 cycle latency, result held in DONE until out_ready.
// Optional divide-by-zero fast path with div_zero flag when SM_NRDIV_DIVZERO_EN is defined.
module sm_nrdiv_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   dividend,
    input  logic [WIDTH:0]   divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   quotient,
    output logic [WIDTH:0]   remainder,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH+1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             qs_q, qs_d;
    logic             rs_q, rs_d;
    logic [WIDTH:0]   quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH+1:0] b_ext, r_shift, r_step, r_fix;

    // Partial remainder stays within [-|b|, |b|), so WIDTH+2 signed bits never overflow.
    assign b_ext   = {2'b00, b_q};
    assign r_shift = {r_q[WIDTH:0], a_q[WIDTH-1]};
    assign r_step  = r_q[WIDTH+1] ? (r_shift + b_ext) : (r_shift - b_ext);
    assign r_fix   = r_q[WIDTH+1] ? (r_q + b_ext) : r_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        a_d     = a_q;
        b_d     = b_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = dividend[WIDTH-1:0];
                    b_d     = divisor[WIDTH-1:0];
                    qs_d    = dividend[WIDTH] ^ divisor[WIDTH];
                    rs_d    = dividend[WIDTH];
                    cnt_d   = CW'(WIDTH);
                    r_d     = '0;
                    q_d     = '0;
                    dz_d    = 1'b0;
                    state_d = CALC;
`ifdef SM_NRDIV_DIVZERO_EN
                    if (divisor[WIDTH-1:0] == '0) begin
                        dz_d    = 1'b1;
                        quo_d   = {dividend[WIDTH] ^ divisor[WIDTH], {WIDTH{1'b1}}};
                        rem_d   = {dividend[WIDTH] & (|dividend[WIDTH-1:0]), dividend[WIDTH-1:0]};
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                r_d   = r_step;
                q_d   = {q_q[WIDTH-2:0], ~r_step[WIDTH+1]};
                a_d   = {a_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                r_d     = r_fix;
                quo_d   = {qs_q & (|q_q), q_q};
                rem_d   = {rs_q & (|r_fix[WIDTH-1:0]), r_fix[WIDTH-1:0]};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            qs_q    <= 1'b0;
            rs_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            a_q     <= a_d;
            b_q     <= b_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
endmodule
